// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and round-robin helper for the drain arbiter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned c_RR_MAX = 32;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_result_t;

    // First set bit of req[0 +: n] scanning upward from start with wrap; start must be < n.
    function automatic rr_result_t rr_next(
        input logic [c_RR_MAX-1:0] req,
        input int unsigned         n,
        input int unsigned         start
    );
        rr_result_t  res;
        int unsigned j;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 0; i < c_RR_MAX; i++) begin
            j = start + i;
            if (j >= n) begin
                j = j - n;
            end
            if ((i < n) && !res.found && req[j[4:0]]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational rotate-and-priority-encode from a start index      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] i_req,
    input  logic [IDX_W-1:0]      i_start,
    output logic                  o_valid,
    output logic [IDX_W-1:0]      o_idx
);

    rr_result_t w_res;

    always_comb begin
        w_res = rr_next(c_RR_MAX'(i_req), NUM_QUEUES, 32'(i_start));
    end

    assign o_valid = w_res.found;
    assign o_idx   = IDX_W'(w_res.idx);

endmodule
`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_drain_arbiter : round-robin burst drain of N fifo_v3 queues into one  |
// | registered valid/ready stage tagged with the source index.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_QUEUES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NUM_QUEUES-1:0]          empty_i,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] data_i,
    output logic [NUM_QUEUES-1:0]          pop_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [IDX_W-1:0]               src_o
);

    localparam int unsigned        c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0]   c_LAST    = IDX_W'(NUM_QUEUES - 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    arb_state_e              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_gnt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [IDX_W-1:0]        r_src;

    logic                    w_load;
    logic                    w_take;
    logic                    w_continue;
    logic [IDX_W-1:0]        w_gnt_inc;
    logic [IDX_W-1:0]        w_scan_start;
    logic                    w_pick_valid;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_sel_valid;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [DATA_WIDTH-1:0]   w_head;

    assign w_load     = (~r_valid | ready_i) & ~flush_i;
    assign w_gnt_inc  = (r_gnt == c_LAST) ? '0 : r_gnt + 1'b1;
    assign w_continue = (r_state == BURST) && (r_cnt < c_MAX_CNT) && !empty_i[r_gnt];

    // On grant end the scan starts past the old grant, so it is naturally checked last.
    assign w_scan_start = (r_state == BURST) ? w_gnt_inc : r_rr_ptr;

    rr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .i_req   (~empty_i),
        .i_start (w_scan_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_sel_valid = w_continue | w_pick_valid;
    assign w_sel_idx   = w_continue ? r_gnt : w_pick_idx;
    assign w_take      = w_load & w_sel_valid;

    always_comb begin
        pop_o = '0;
        if (rst_ni && w_take) begin
            pop_o[w_sel_idx] = 1'b1;
        end
    end

    always_comb begin
        w_head = '0;
        for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
            if (w_sel_idx == IDX_W'(k)) begin
                w_head = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
        end else if (flush_i) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            if ((r_state == BURST) && !w_continue) begin
                r_rr_ptr <= w_gnt_inc;
            end
            if (w_sel_valid) begin
                r_state <= BURST;
                r_valid <= 1'b1;
                r_data  <= w_head;
                r_src   <= w_sel_idx;
                r_gnt   <= w_sel_idx;
                r_cnt   <= w_continue ? r_cnt + 1'b1 : c_CNT_W'(1);
            end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign src_o   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_drain_arbiter : randomized scoreboard bench for fifo_drain_arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fifo_drain_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           flush_i = 1'b0;
    logic           ready_i = 1'b0;
    logic [N-1:0]   empty_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   pop_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic [IW-1:0]  src_o;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .NUM_QUEUES (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .empty_i (empty_i),
        .data_i  (data_i),
        .pop_o   (pop_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .src_o   (src_o)
    );

    typedef struct packed {
        logic [IW-1:0] src;
        logic [W-1:0]  data;
    } exp_t;

    logic [W-1:0] tq [N][$];
    exp_t         sb [$];
    int           acc_log [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // Reference model: grant owner, burst length, round-robin pointer, output valid.
    bit m_valid = 0, m_busy = 0;
    int m_gnt = 0, m_cnt = 0, m_ptr = 0;
    bit e_load, e_hit, e_cont;
    int e_sel;

    bit            h_prev = 0;
    logic [W-1:0]  h_data;
    logic [IW-1:0] h_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            empty_i[k]        = (tq[k].size() == 0);
            data_i[k*W +: W]  = (tq[k].size() != 0) ? tq[k][0] : '0;
        end
    endtask

    task automatic predict();
        int st;
        logic [N-1:0] exp_pop;
        e_load = (!m_valid || ready_i) && !flush_i;
        e_cont = m_busy && (m_cnt < MB) && (tq[m_gnt].size() > 0);
        e_hit  = 0;
        e_sel  = 0;
        if (e_cont) begin
            e_hit = 1;
            e_sel = m_gnt;
        end else begin
            st = m_busy ? (m_gnt + 1) % N : m_ptr;
            for (int i = 0; i < N; i++) begin
                if (!e_hit && tq[(st + i) % N].size() > 0) begin
                    e_hit = 1;
                    e_sel = (st + i) % N;
                end
            end
        end
        exp_pop = '0;
        if (e_load && e_hit) exp_pop[e_sel] = 1'b1;
        chk("pop_o", 64'(pop_o), 64'(exp_pop));
        chk("valid_o", 64'(valid_o), 64'(m_valid));
    endtask

    task automatic apply();
        exp_t e;
        if (flush_i) begin
            m_valid = 0; m_busy = 0; m_ptr = 0; m_cnt = 0; m_gnt = 0;
            sb.delete();
        end else if (e_load) begin
            if (m_busy && !e_cont) m_ptr = (m_gnt + 1) % N;
            if (e_hit) begin
                e.src  = IW'(e_sel);
                e.data = tq[e_sel][0];
                sb.push_back(e);
                void'(tq[e_sel].pop_front());
                m_cnt   = e_cont ? m_cnt + 1 : 1;
                m_gnt   = e_sel;
                m_valid = 1;
                m_busy  = 1;
            end else begin
                m_valid = 0;
                m_busy  = 0;
            end
        end
        drive_inputs();
    endtask

    task automatic cycle();
        @(negedge clk);
        predict();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic fill(input int k, input int cnt);
        for (int i = 0; i < cnt; i++) tq[k].push_back($urandom);
        drive_inputs();
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        bit busy;
        ready_i = 1'b1;
        busy = 1;
        while (busy && guard < 400) begin
            cycle();
            guard++;
            busy = m_valid;
            for (int k = 0; k < N; k++) if (tq[k].size() != 0) busy = 1;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", guard);
        end
        chk("sb_empty_after_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_log(input string name, input int exp_q[$]);
        chk({name, "_len"}, 64'(acc_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
            chk(name, 64'(acc_log[i]), 64'(exp_q[i]));
    endtask

    // Monitor: consumes accepted words against the scoreboard and checks hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni) begin
            if (h_prev) begin
                chk("hold_data", 64'(data_o), 64'(h_data));
                chk("hold_src", 64'(src_o), 64'(h_src));
            end
            if (valid_o && ready_i && !flush_i) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got src %0d data %0h, required no word", src_o, data_o);
                end else begin
                    e = sb.pop_front();
                    chk("data_o", 64'(data_o), 64'(e.data));
                    chk("src_o", 64'(src_o), 64'(e.src));
                end
                acc_log.push_back(int'(src_o));
            end
            h_prev = valid_o && !ready_i && !flush_i;
            h_data = data_o;
            h_src  = src_o;
        end else begin
            h_prev = 0;
        end
    end

    initial begin
        int exp_q[$];
        ready_i = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_src", 64'(src_o), 64'd0);
        chk("rst_pop", 64'(pop_o), 64'd0);
        rst_ni = 1'b1;

        // Single queue with three words.
        fill(2, 3);
        acc_log.delete();
        wait_drain();
        exp_q = '{2, 2, 2};
        check_log("single_q_src", exp_q);

        // Round-robin with bursts, starting from pointer 0.
        pulse_flush();
        for (int k = 0; k < N; k++) fill(k, 6);
        acc_log.delete();
        wait_drain();
        exp_q.delete();
        for (int r = 0; r < N; r++) for (int j = 0; j < MB; j++) exp_q.push_back(r);
        for (int r = 0; r < N; r++) for (int j = 0; j < 6 - MB; j++) exp_q.push_back(r);
        check_log("rr_burst_src", exp_q);

        // Backpressure mid-burst.
        fill(1, 6);
        repeat (2) cycle();
        ready_i = 1'b0;
        repeat (5) cycle();
        wait_drain();

        // Early burst end with wrap from pointer 3, then pointer lands on 1.
        pulse_flush();
        fill(2, 1);
        wait_drain();
        fill(3, 1);
        fill(0, 2);
        acc_log.delete();
        wait_drain();
        fill(0, 1);
        fill(1, 1);
        wait_drain();
        exp_q = '{3, 0, 0, 1, 0};
        check_log("wrap_src", exp_q);

        // Flush mid-burst: next grant scans from queue 0.
        fill(1, 4);
        fill(0, 2);
        repeat (3) cycle();
        pulse_flush();
        acc_log.delete();
        wait_drain();
        chk("flush_restart_src", 64'(acc_log.size() > 0 ? acc_log[0] : -1), 64'd0);

        // Reset mid-burst: arbitration restarts from queue 0.
        pulse_flush();
        fill(3, 6);
        repeat (2) cycle();
        fill(1, 2);
        cycle();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("amid_rst_valid", 64'(valid_o), 64'd0);
        chk("amid_rst_data", 64'(data_o), 64'd0);
        chk("amid_rst_src", 64'(src_o), 64'd0);
        chk("amid_rst_pop", 64'(pop_o), 64'd0);
        m_valid = 0; m_busy = 0; m_ptr = 0; m_cnt = 0; m_gnt = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        acc_log.delete();
        wait_drain();
        chk("reset_restart_src", 64'(acc_log.size() > 0 ? acc_log[0] : -1), 64'd1);

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 99) < 20 && tq[k].size() < 10) tq[k].push_back($urandom);
            drive_inputs();
            ready_i = ($urandom_range(0, 99) < 70);
            flush_i = ($urandom_range(0, 199) == 0);
            cycle();
            flush_i = 1'b0;
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
